store_buffer: RTL and testbench

- Sits between the single-cycle RV64 core's store port and data memory.
- Captures each committed store (memwrite/address/data) into a small in-order FIFO and drains it to memory over a valid/ready handshake.
- Decouples the core from memory write latency.
- Provides store-to-load forwarding and a stall signal when full.

---
 rtl/sb_pkg.sv | 35 +++
 rtl/sb_fwd_match.sv | 61 ++++++
 rtl/store_buffer.sv | 118 +++++++++++
 tb/tb_store_buffer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sb_pkg
// Purpose  : Shared types and constants for the store buffer.
//            - sb_entry_t : one buffered store {addr_hi, data, mask}
//            - SB_DEPTH_DEFAULT, MASK_FULL, entry field widths
//            - clog2()    : pointer width helper for elaboration-time sizing
// Revision : 1.0 - initial release
// ============================================================================
package sb_pkg;

  localparam int SB_DEPTH_DEFAULT = 4;
  localparam int SB_ADDR_W        = 64;
  localparam int SB_DATA_W        = 64;
  localparam int SB_MASK_W        = SB_DATA_W / 8;

  localparam logic [SB_MASK_W-1:0] MASK_FULL = '1;

  // Only the doubleword-aligned part of the address is kept; the store is
  // always presented to memory with the low 3 address bits cleared.
  typedef struct packed {
    logic [SB_ADDR_W-4:0] addr_hi;
    logic [SB_DATA_W-1:0] data;
    logic [SB_MASK_W-1:0] mask;
  } sb_entry_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sb_fwd_match.sv
`default_nettype none
// ============================================================================
// Module   : sb_fwd_match
// Purpose  : Combinational youngest-first search of the store buffer for a
//            load address. Reports the winning entry index and whether its
//            byte mask covers the whole doubleword (hit) or not (partial).
// Ports    : i_entries  - entry array
//            i_valid    - per-slot occupancy
//            i_head     - oldest slot
//            i_count    - number of occupied slots
//            i_ld_addr  - load byte address
//            o_hit_idx  - slot of the youngest matching entry
//            o_hit      - winner has a full mask
//            o_partial  - winner has a partial mask
// Revision : 1.0 - initial release
// ============================================================================
module sb_fwd_match
  import sb_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH_DEFAULT,
  parameter int ADDR_W = SB_ADDR_W
) (
  input  sb_entry_t                 i_entries [DEPTH],
  input  logic [DEPTH-1:0]          i_valid,
  input  logic [clog2(DEPTH)-1:0]   i_head,
  input  logic [clog2(DEPTH):0]     i_count,
  input  logic [ADDR_W-1:0]         i_ld_addr,
  output logic [clog2(DEPTH)-1:0]   o_hit_idx,
  output logic                      o_hit,
  output logic                      o_partial
);

  localparam int c_PTR_W = clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [c_PTR_W-1:0] w_idx;
  logic [c_PTR_W-1:0] w_win;
  logic               w_found;

  // Walk from oldest to youngest; a later match overwrites an earlier one so
  // the entry nearest the tail wins.
  always_comb begin
    w_idx   = '0;
    w_win   = '0;
    w_found = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = i_head + c_PTR_W'(k);
      if (i_valid[w_idx] && (c_CNT_W'(k) < i_count) &&
          (i_entries[w_idx].addr_hi == i_ld_addr[ADDR_W-1:3])) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign o_hit_idx = w_win;
  assign o_hit     = w_found && (i_entries[w_win].mask == MASK_FULL);
  assign o_partial = w_found && (i_entries[w_win].mask != MASK_FULL);

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Purpose  : In-order store FIFO between the core store port and data memory,
//            with store-to-load forwarding and a full-stall indication.
// Ports    : clk, rst (async, active-low)
//            st_valid/st_addr/st_data/st_mask/st_ready      - core store port
//            mem_req_valid/addr/data/mask, mem_req_ready    - memory drain
//            ld_addr, ld_hit, ld_data, ld_conflict          - forwarding
//            empty                                          - no stores held
// Revision : 1.0 - initial release
// ============================================================================
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH_DEFAULT,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  st_valid,
  input  logic [ADDR_W-1:0]     st_addr,
  input  logic [DATA_W-1:0]     st_data,
  input  logic [DATA_W/8-1:0]   st_mask,
  output logic                  st_ready,
  output logic                  mem_req_valid,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic [DATA_W-1:0]     mem_req_data,
  output logic [DATA_W/8-1:0]   mem_req_mask,
  input  logic                  mem_req_ready,
  input  logic [ADDR_W-1:0]     ld_addr,
  output logic                  ld_hit,
  output logic [DATA_W-1:0]     ld_data,
  output logic                  ld_conflict,
  output logic                  empty
);

  localparam int c_PTR_W = clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  sb_entry_t          r_entries [DEPTH];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_CNT_W-1:0] r_count;

  logic               w_push;
  logic               w_pop;
  logic [DEPTH-1:0]   w_valid;
  logic [c_PTR_W-1:0] w_hit_idx;
  logic               w_hit;
  logic               w_partial;

  // Full/empty come only from the count; head==tail is ambiguous.
  assign st_ready      = (r_count != c_CNT_W'(DEPTH));
  assign mem_req_valid = (r_count != '0);
  assign empty         = (r_count == '0);

  assign w_push = st_valid && st_ready;
  assign w_pop  = mem_req_valid && mem_req_ready;

  assign mem_req_addr = {r_entries[r_head].addr_hi, 3'b000};
  assign mem_req_data = r_entries[r_head].data;
  assign mem_req_mask = r_entries[r_head].mask;

  // A slot is occupied when its distance from head is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_valid
    logic [c_PTR_W-1:0] w_age;
    assign w_age      = c_PTR_W'(i) - r_head;
    assign w_valid[i] = ({1'b0, w_age} < r_count);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_entries[r_tail] <= '{addr_hi: st_addr[ADDR_W-1:3],
                               data:    st_data,
                               mask:    st_mask};
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  sb_fwd_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fwd_match (
    .i_entries (r_entries),
    .i_valid   (w_valid),
    .i_head    (r_head),
    .i_count   (r_count),
    .i_ld_addr (ld_addr),
    .o_hit_idx (w_hit_idx),
    .o_hit     (w_hit),
    .o_partial (w_partial)
  );

  assign ld_hit      = w_hit;
  assign ld_conflict = w_partial;
  assign ld_data     = w_hit ? r_entries[w_hit_idx].data : '0;

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buffer
// Purpose  : Self-checking bench for store_buffer. A queue-based model of the
//            buffer is compared against the DUT on every falling edge, and
//            directed scenarios pin literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int MASK_W = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic [MASK_W-1:0] st_mask;
  logic              st_ready;
  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_data;
  logic [MASK_W-1:0] mem_req_mask;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_hit;
  logic [DATA_W-1:0] ld_data;
  logic              ld_conflict;
  logic              empty;

  store_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .st_valid      (st_valid),
    .st_addr       (st_addr),
    .st_data       (st_data),
    .st_mask       (st_mask),
    .st_ready      (st_ready),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_data  (mem_req_data),
    .mem_req_mask  (mem_req_mask),
    .mem_req_ready (mem_req_ready),
    .ld_addr       (ld_addr),
    .ld_hit        (ld_hit),
    .ld_data       (ld_data),
    .ld_conflict   (ld_conflict),
    .empty         (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] drained[$];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue. Acceptance and drain decisions use the
  // queue length before the edge, so a full buffer never accepts a store.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
    end else begin
      automatic bit do_push = st_valid && (mq.size() != DEPTH);
      automatic bit do_pop  = mem_req_ready && (mq.size() != 0);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back('{st_addr & ~64'h7, st_data, st_mask});
    end
  end

  function automatic void model_fwd(input logic [63:0] a, output bit hit,
                                    output bit conf, output logic [63:0] d);
    hit  = 1'b0;
    conf = 1'b0;
    d    = '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].addr[63:3] == a[63:3]) begin
        if (mq[i].mask == 8'hFF) begin
          hit = 1'b1;
          d   = mq[i].data;
        end else begin
          conf = 1'b1;
        end
        break;
      end
    end
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      automatic bit          e_hit;
      automatic bit          e_conf;
      automatic logic [63:0] e_data;
      chk("st_ready", st_ready, mq.size() != DEPTH);
      chk("empty", empty, mq.size() == 0);
      chk("mem_req_valid", mem_req_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("mem_req_addr", mem_req_addr, mq[0].addr);
        chk("mem_req_data", mem_req_data, mq[0].data);
        chk("mem_req_mask", mem_req_mask, 64'(mq[0].mask));
      end
      model_fwd(ld_addr, e_hit, e_conf, e_data);
      chk("ld_hit", ld_hit, e_hit);
      chk("ld_conflict", ld_conflict, e_conf);
      chk("ld_data", ld_data, e_data);
      if (mem_req_valid && mem_req_ready) drained.push_back(mem_req_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_mask  = m;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int budget);
    int c;
    c = 0;
    while (!empty && c < budget) begin
      tick();
      c++;
    end
    chk(name, empty, 1'b1);
  endtask

  initial begin
    rst           = 1'b0;
    st_valid      = 1'b0;
    st_addr       = '0;
    st_data       = '0;
    st_mask       = '0;
    mem_req_ready = 1'b0;
    ld_addr       = '0;

    // Reset held for three cycles.
    repeat (3) tick();
    chk("rst_empty", empty, 1'b1);
    chk("rst_st_ready", st_ready, 1'b1);
    chk("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk("rst_mem_req_addr", mem_req_addr, 64'h0);
    chk("rst_mem_req_data", mem_req_data, 64'h0);
    chk("rst_mem_req_mask", mem_req_mask, 64'h0);
    chk("rst_ld_hit", ld_hit, 1'b0);
    chk("rst_ld_conflict", ld_conflict, 1'b0);
    chk("rst_ld_data", ld_data, 64'h0);
    rst = 1'b1;
    tick();

    // Single store, drained immediately.
    mem_req_ready = 1'b1;
    push(64'h8000_1008, 64'hDEAD_BEEF, 8'hFF);
    chk("single_valid", mem_req_valid, 1'b1);
    chk("single_addr", mem_req_addr, 64'h8000_1008);
    chk("single_data", mem_req_data, 64'hDEAD_BEEF);
    chk("single_mask", mem_req_mask, 64'hFF);
    tick();
    chk("single_empty_after", empty, 1'b1);

    // Fill with backpressure; the fifth store must be refused.
    mem_req_ready = 1'b0;
    drained.delete();
    for (int i = 0; i < 4; i++) begin
      chk("fill_st_ready_open", st_ready, 1'b1);
      push(64'h100 + 64'(8 * i), 64'hA0 + 64'(i), 8'hFF);
    end
    chk("fill_st_ready_full", st_ready, 1'b0);
    st_valid = 1'b1;
    st_addr  = 64'h200;
    st_data  = 64'hA4;
    st_mask  = 8'hFF;
    tick();
    st_valid = 1'b0;
    chk("fill_still_full", st_ready, 1'b0);
    repeat (2) tick();
    chk("fill_hold_addr", mem_req_addr, 64'h100);
    chk("fill_hold_data", mem_req_data, 64'hA0);
    mem_req_ready = 1'b1;
    wait_empty("fill_drain_timeout", 10);
    chk("fill_drain_count", 64'(drained.size()), 64'd4);
    for (int i = 0; i < drained.size() && i < 4; i++)
      chk("fill_drain_order", drained[i], 64'hA0 + 64'(i));
    chk("fill_st_ready_after", st_ready, 1'b1);

    // Steady-state push and pop at occupancy two; pointers wrap repeatedly.
    mem_req_ready = 1'b0;
    drained.delete();
    push(64'h400, 64'hB0, 8'hFF);
    push(64'h408, 64'hB1, 8'hFF);
    mem_req_ready = 1'b1;
    for (int i = 2; i < 12; i++) begin
      st_valid = 1'b1;
      st_addr  = 64'h400 + 64'(8 * i);
      st_data  = 64'hB0 + 64'(i);
      st_mask  = 8'hFF;
      tick();
      chk("steady_valid", mem_req_valid, 1'b1);
      chk("steady_ready", st_ready, 1'b1);
    end
    st_valid = 1'b0;
    wait_empty("steady_drain_timeout", 10);
    chk("steady_drain_count", 64'(drained.size()), 64'd12);
    for (int i = 0; i < drained.size() && i < 12; i++)
      chk("steady_drain_order", drained[i], 64'hB0 + 64'(i));

    // Forwarding: youngest full-mask match wins; partial mask conflicts.
    mem_req_ready = 1'b0;
    push(64'h1000, 64'h11, 8'hFF);
    push(64'h1000, 64'h22, 8'hFF);
    ld_addr = 64'h1004;
    #1;
    chk("fwd_hit", ld_hit, 1'b1);
    chk("fwd_data", ld_data, 64'h22);
    chk("fwd_no_conflict", ld_conflict, 1'b0);
    push(64'h2000, 64'h33, 8'h0F);
    ld_addr = 64'h2000;
    #1;
    chk("fwd_conflict", ld_conflict, 1'b1);
    chk("fwd_conflict_no_hit", ld_hit, 1'b0);
    chk("fwd_conflict_data", ld_data, 64'h0);
    ld_addr = 64'h3000;
    #1;
    chk("fwd_miss_hit", ld_hit, 1'b0);
    chk("fwd_miss_conflict", ld_conflict, 1'b0);
    chk("fwd_miss_data", ld_data, 64'h0);
    ld_addr = 64'h1000;
    mem_req_ready = 1'b1;
    wait_empty("fwd_drain_timeout", 10);
    ld_addr = 64'h3000;
    #1;
    chk("empty_lookup_hit", ld_hit, 1'b0);
    chk("empty_lookup_conflict", ld_conflict, 1'b0);
    chk("empty_lookup_data", ld_data, 64'h0);

    // Reset during a pending drain drops valid without a clock edge.
    mem_req_ready = 1'b0;
    push(64'h5000, 64'h55, 8'hFF);
    push(64'h5008, 64'h56, 8'hFF);
    chk("pre_rst_valid", mem_req_valid, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", mem_req_valid, 1'b0);
    chk("async_rst_empty", empty, 1'b1);
    chk("async_rst_st_ready", st_ready, 1'b1);
    tick();
    rst = 1'b1;
    mem_req_ready = 1'b1;
    repeat (2) tick();
    chk("post_rst_empty", empty, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
